// File: rtl/gs_readout_scheduler.sv
// rtl/gs_readout_scheduler.sv - command-driven raw-signal readout sequencer
module gs_readout_scheduler #(
    parameter int         SAMPLE_DEPTH = 67,
    parameter int         READ_LATENCY = 1,
    parameter logic [7:0] HDR_TAG      = 8'hA5
) (
    input  logic        iClk,
    input  logic        iReset,
    input  logic [31:0] i32Cmd,
    input  logic        iCmdEmpty,
    output logic        oCmdRdEn,
    input  logic [15:0] i16Sample,
    output logic [7:0]  o8Addr,
    output logic [7:0]  o8SignSelec,
    output logic        oWriteRawSignal,
    output logic [15:0] o16RawSignal,
    input  logic        iRawFull,
    output logic        oBusy,
    output logic        oDone,
    output logic        oCmdErr
);

    localparam logic [8:0] DEPTH9    = 9'(SAMPLE_DEPTH);
    localparam logic [7:0] DEPTH8    = 8'(SAMPLE_DEPTH);
    localparam logic [2:0] WAIT_LAST = 3'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_HEADER,
        S_ADDR,
        S_WAIT,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cmd_q;
    logic [7:0]  mask_q;
    logic [7:0]  cnt_q;
    logic [7:0]  k_q;
    logic [7:0]  addr_q;
    logic [7:0]  sel_q;
    logic [2:0]  idx_q;
    logic [2:0]  wcnt_q;
    logic [15:0] data_q;
    logic        busy_q;
    logic        err_q;

    logic [7:0]  cmd_mask;
    logic [7:0]  cmd_rsv;
    logic [7:0]  cmd_start;
    logic [7:0]  cmd_count;
    logic [7:0]  mask_rem;
    logic        decode_err;
    logic        pop;

    // Index of the lowest set bit; signals are walked in ascending order.
    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    assign cmd_mask  = cmd_q[31:24];
    assign cmd_rsv   = cmd_q[23:16];
    assign cmd_start = cmd_q[15:8];
    assign cmd_count = cmd_q[7:0];
    assign mask_rem  = mask_q & ~(8'd1 << idx_q);
    assign pop       = (state_q == S_IDLE) && !iCmdEmpty;

    // Start+count is compared at 9 bits so a large count cannot wrap into range.
    assign decode_err = (cmd_mask == 8'd0) || (cmd_rsv != 8'd0) ||
                        ({1'b0, cmd_start} >= DEPTH9) ||
                        (({1'b0, cmd_start} + {1'b0, cmd_count}) > DEPTH9);

    assign o8Addr      = addr_q;
    assign o8SignSelec = sel_q;
    assign oBusy       = busy_q;
    assign oCmdErr     = err_q;

    // State register.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and strobes; write strobes react combinationally to iRawFull.
    always_comb begin
        state_d         = state_q;
        oCmdRdEn        = 1'b0;
        oWriteRawSignal = 1'b0;
        o16RawSignal    = 16'd0;
        oDone           = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!iCmdEmpty) begin
                    oCmdRdEn = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: state_d = decode_err ? S_IDLE : S_HEADER;
            S_HEADER: begin
                o16RawSignal = {HDR_TAG, 5'd0, idx_q};
                if (!iRawFull) begin
                    oWriteRawSignal = 1'b1;
                    state_d         = S_ADDR;
                end
            end
            S_ADDR: state_d = S_WAIT;
            S_WAIT: begin
                if (wcnt_q == WAIT_LAST) state_d = S_WRITE;
            end
            S_WRITE: begin
                o16RawSignal = data_q;
                if (!iRawFull) begin
                    oWriteRawSignal = 1'b1;
                    state_d = ((k_q + 8'd1) == cnt_q) ? S_NEXT : S_ADDR;
                end
            end
            S_NEXT: state_d = (mask_rem != 8'd0) ? S_HEADER : S_DONE;
            S_DONE: begin
                oDone   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command latch, per-signal walk counters, memory address and captured sample.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            cmd_q  <= 32'd0;
            mask_q <= 8'd0;
            cnt_q  <= 8'd0;
            k_q    <= 8'd0;
            addr_q <= 8'd0;
            sel_q  <= 8'd0;
            idx_q  <= 3'd0;
            wcnt_q <= 3'd0;
            data_q <= 16'd0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        cmd_q  <= i32Cmd;
                        busy_q <= 1'b1;
                        err_q  <= 1'b0;
                    end
                end
                S_DECODE: begin
                    if (decode_err) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        mask_q <= cmd_mask;
                        idx_q  <= lowest_bit(cmd_mask);
                        k_q    <= 8'd0;
                        cnt_q  <= (cmd_count == 8'd0) ? (DEPTH8 - cmd_start) : cmd_count;
                    end
                end
                S_ADDR: begin
                    addr_q <= cmd_start + k_q;
                    sel_q  <= 8'd1 << idx_q;
                    wcnt_q <= 3'd0;
                end
                S_WAIT: begin
                    wcnt_q <= wcnt_q + 3'd1;
                    if (wcnt_q == WAIT_LAST) data_q <= i16Sample;
                end
                S_WRITE: begin
                    if (!iRawFull) k_q <= k_q + 8'd1;
                end
                S_NEXT: begin
                    mask_q <= mask_rem;
                    idx_q  <= lowest_bit(mask_rem);
                    k_q    <= 8'd0;
                    if (mask_rem == 8'd0) begin
                        addr_q <= 8'd0;
                        sel_q  <= 8'd0;
                        busy_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gs_readout_scheduler.sv
// tb/tb_gs_readout_scheduler.sv - randomized model-checked bench for gs_readout_scheduler
module tb_gs_readout_scheduler;

    localparam int DEPTH = 67;

    logic        iClk;
    logic        iReset;
    logic [31:0] i32Cmd;
    logic        iCmdEmpty;
    logic        oCmdRdEn;
    logic [15:0] i16Sample;
    logic [7:0]  o8Addr;
    logic [7:0]  o8SignSelec;
    logic        oWriteRawSignal;
    logic [15:0] o16RawSignal;
    logic        iRawFull;
    logic        oBusy;
    logic        oDone;
    logic        oCmdErr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int full_until = 0;
    bit bp_rand = 0;
    bit active = 0;
    int busy_chk_at = -1;
    int err_chk_at = -1;
    bit fifo_rd;
    bit cmd_valid;

    logic [31:0] cmdq[$];
    logic [15:0] exp_q[$];
    logic [15:0] wlog[$];
    int          wcyc[$];
    int          pop_cyc[$];
    int          done_cyc[$];

    gs_readout_scheduler #(
        .SAMPLE_DEPTH(DEPTH),
        .READ_LATENCY(1),
        .HDR_TAG(8'hA5)
    ) dut (
        .iClk(iClk),
        .iReset(iReset),
        .i32Cmd(i32Cmd),
        .iCmdEmpty(iCmdEmpty),
        .oCmdRdEn(oCmdRdEn),
        .i16Sample(i16Sample),
        .o8Addr(o8Addr),
        .o8SignSelec(o8SignSelec),
        .oWriteRawSignal(oWriteRawSignal),
        .o16RawSignal(o16RawSignal),
        .iRawFull(iRawFull),
        .oBusy(oBusy),
        .oDone(oDone),
        .oCmdErr(oCmdErr)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // Signal memory: word = (signal+1)*256 + address; a non-one-hot select reads 0xDEAD.
    function automatic logic [15:0] mem_word(input logic [7:0] a, input logic [7:0] sel);
        int n;
        int idx;
        n = 0;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) begin
                n++;
                idx = i;
            end
        end
        if (n != 1) return 16'hDEAD;
        return 16'((idx + 1) * 256 + int'(a));
    endfunction

    always_comb i16Sample = mem_word(o8Addr, o8SignSelec);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input int i, input logic [15:0] exp);
        checks++;
        if (i >= wlog.size()) begin
            errors++;
            $display("FAIL %s: word %0d missing (only %0d written), expected %h", name, i, wlog.size(), exp);
        end else if (wlog[i] !== exp) begin
            errors++;
            $display("FAIL %s: word %0d got %h expected %h", name, i, wlog[i], exp);
        end
    endtask

    // Expected stream for one command, straight from the field rules.
    task automatic model_cmd(input logic [31:0] c, output bit valid);
        logic [7:0] m;
        int r, s, cc, n;
        m  = c[31:24];
        r  = int'(c[23:16]);
        s  = int'(c[15:8]);
        cc = int'(c[7:0]);
        valid = (m != 8'd0) && (r == 0) && (s < DEPTH) && (s + cc <= DEPTH);
        if (valid) begin
            n = (cc == 0) ? DEPTH - s : cc;
            for (int b = 0; b < 8; b++) begin
                if (m[b]) begin
                    exp_q.push_back(16'hA500 | 16'(b));
                    for (int k = 0; k < n; k++) exp_q.push_back(16'((b + 1) * 256 + s + k));
                end
            end
        end
    endtask

    // Host command FIFO, show-ahead; advances just after a popping edge.
    initial begin
        i32Cmd = 32'd0;
        iCmdEmpty = 1'b1;
        forever begin
            @(negedge iClk);
            fifo_rd = oCmdRdEn;
            @(posedge iClk);
            #1;
            if (fifo_rd && cmdq.size() > 0) void'(cmdq.pop_front());
            if (cmdq.size() > 0) begin
                i32Cmd = cmdq[0];
                iCmdEmpty = 1'b0;
            end else begin
                i32Cmd = 32'd0;
                iCmdEmpty = 1'b1;
            end
        end
    end

    // Raw FIFO full: forced window plus optional random backpressure.
    initial begin
        iRawFull = 1'b0;
        forever begin
            @(posedge iClk);
            #1;
            iRawFull = (cyc < full_until) || (bp_rand && ($urandom_range(0, 3) == 0));
        end
    end

    // Compare process: every cycle against the model.
    initial begin
        forever begin
            @(negedge iClk);
            cyc++;
            if (iReset) begin
                if (oWriteRawSignal) chk("write_in_reset", 32'(oWriteRawSignal), 32'd0);
            end else begin
                chk("sel_onehot0", 32'($onehot0(o8SignSelec)), 32'd1);
                chk("addr_range", 32'(o8Addr < 8'(DEPTH)), 32'd1);
                if (cyc == busy_chk_at) begin
                    chk("busy_after_pop", 32'(oBusy), 32'd1);
                    chk("err_cleared_by_pop", 32'(oCmdErr), 32'd0);
                end
                if (cyc == err_chk_at) begin
                    chk("err_set", 32'(oCmdErr), 32'd1);
                    chk("busy_drop_on_err", 32'(oBusy), 32'd0);
                    active = 0;
                    err_chk_at = -1;
                end
                if (oCmdRdEn) begin
                    chk("pop_while_busy", 32'(active), 32'd0);
                    chk("pop_nonempty", 32'(iCmdEmpty), 32'd0);
                    chk("busy_low_at_pop", 32'(oBusy), 32'd0);
                    model_cmd(i32Cmd, cmd_valid);
                    active = 1;
                    pop_cyc.push_back(cyc);
                    busy_chk_at = cyc + 1;
                    if (!cmd_valid) err_chk_at = cyc + 2;
                end
                if (oWriteRawSignal) begin
                    chk("write_when_full", 32'(iRawFull), 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got %h expected no write", o16RawSignal);
                    end else begin
                        chk("write_data", 32'(o16RawSignal), 32'(exp_q.pop_front()));
                    end
                    wlog.push_back(o16RawSignal);
                    wcyc.push_back(cyc);
                end
                if (oDone) begin
                    chk("done_while_active", 32'(active), 32'd1);
                    chk("done_all_written", 32'(exp_q.size()), 32'd0);
                    chk("busy_low_at_done", 32'(oBusy), 32'd0);
                    chk("sel_zero_at_done", 32'(o8SignSelec), 32'd0);
                    chk("addr_zero_at_done", 32'(o8Addr), 32'd0);
                    active = 0;
                    done_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic clear_logs();
        wlog.delete();
        wcyc.delete();
        pop_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((cmdq.size() != 0 || active) && n < limit) begin
            @(negedge iClk);
            #1;
            n++;
        end
        chk("idle_timeout", 32'(cmdq.size() != 0 || active), 32'd0);
        repeat (2) @(negedge iClk);
        #1;
    endtask

    task automatic wait_writes(input int cnt, input int limit);
        int n;
        n = 0;
        while (wlog.size() < cnt && n < limit) begin
            @(negedge iClk);
            #1;
            n++;
        end
        chk("write_wait_timeout", 32'(wlog.size() < cnt), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rden"}, 32'(oCmdRdEn), 32'd0);
        chk({tag, "_wr"}, 32'(oWriteRawSignal), 32'd0);
        chk({tag, "_data"}, 32'(o16RawSignal), 32'd0);
        chk({tag, "_addr"}, 32'(o8Addr), 32'd0);
        chk({tag, "_sel"}, 32'(o8SignSelec), 32'd0);
        chk({tag, "_busy"}, 32'(oBusy), 32'd0);
        chk({tag, "_done"}, 32'(oDone), 32'd0);
        chk({tag, "_err"}, 32'(oCmdErr), 32'd0);
    endtask

    logic [15:0] t2_words[8] = '{16'hA500, 16'h0140, 16'h0141, 16'h0142,
                                  16'hA502, 16'h0340, 16'h0341, 16'h0342};

    initial begin
        int n0;
        int total;
        logic [31:0] rc;
        int rs, rcnt;

        iReset = 1'b1;
        repeat (3) @(negedge iClk);
        #1;
        chk_all_zero("reset");
        iReset = 1'b0;
        repeat (2) @(negedge iClk);
        #1;

        // Single signal, three samples at the base rate.
        clear_logs();
        cmdq.push_back(32'h01_00_00_03);
        wait_idle(200);
        chk("t1_nwrites", 32'(wlog.size()), 32'd4);
        chk_word("t1_w0", 0, 16'hA500);
        chk_word("t1_w1", 1, 16'h0100);
        chk_word("t1_w2", 2, 16'h0101);
        chk_word("t1_w3", 3, 16'h0102);
        if (wcyc.size() == 4) begin
            chk("t1_hdr_to_s0", 32'(wcyc[1] - wcyc[0]), 32'd3);
            chk("t1_s0_to_s1", 32'(wcyc[2] - wcyc[1]), 32'd3);
            chk("t1_s1_to_s2", 32'(wcyc[3] - wcyc[2]), 32'd3);
        end
        chk("t1_pops", 32'(pop_cyc.size()), 32'd1);
        chk("t1_dones", 32'(done_cyc.size()), 32'd1);

        // Two signals, count 0 means run to the end of memory.
        clear_logs();
        cmdq.push_back(32'h05_00_40_00);
        wait_idle(300);
        chk("t2_nwrites", 32'(wlog.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk_word("t2_word", i, t2_words[i]);

        // Malformed commands, then a valid one clears the error.
        clear_logs();
        cmdq.push_back(32'h00_00_00_04);
        cmdq.push_back(32'h01_01_00_01);
        cmdq.push_back(32'h01_00_42_02);
        wait_idle(200);
        chk("t3_no_writes", 32'(wlog.size()), 32'd0);
        chk("t3_no_done", 32'(done_cyc.size()), 32'd0);
        chk("t3_pops", 32'(pop_cyc.size()), 32'd3);
        chk("t3_err_sticky", 32'(oCmdErr), 32'd1);
        cmdq.push_back(32'h01_00_00_01);
        wait_idle(200);
        chk("t3_err_cleared", 32'(oCmdErr), 32'd0);
        chk_word("t3_hdr", 0, 16'hA500);
        chk_word("t3_s0", 1, 16'h0100);

        // Five cycles of full starting right after the first sample.
        clear_logs();
        cmdq.push_back(32'h02_00_00_04);
        wait_writes(2, 200);
        full_until = cyc + 5;
        wait_idle(300);
        chk("t4_nwrites", 32'(wlog.size()), 32'd5);
        chk_word("t4_w0", 0, 16'hA501);
        chk_word("t4_w1", 1, 16'h0200);
        chk_word("t4_w2", 2, 16'h0201);
        chk_word("t4_w3", 3, 16'h0202);
        chk_word("t4_w4", 4, 16'h0203);
        if (wcyc.size() >= 3) chk("t4_stall_gap", 32'(wcyc[2] - wcyc[1]), 32'd6);

        // Back-to-back commands: second pop right after the first DONE.
        clear_logs();
        cmdq.push_back(32'h01_00_00_02);
        cmdq.push_back(32'h02_00_00_01);
        wait_idle(300);
        chk("t5_pops", 32'(pop_cyc.size()), 32'd2);
        chk("t5_dones", 32'(done_cyc.size()), 32'd2);
        if (pop_cyc.size() == 2 && done_cyc.size() >= 1)
            chk("t5_pop_after_done", 32'(pop_cyc[1] - done_cyc[0]), 32'd1);
        chk("t5_nwrites", 32'(wlog.size()), 32'd5);

        // Asynchronous reset in the middle of a sample wait.
        clear_logs();
        cmdq.push_back(32'h80_00_00_10);
        wait_writes(2, 200);
        @(negedge iClk);
        #1;
        @(negedge iClk);
        #1;
        chk("t6_sel_before_rst", 32'(o8SignSelec), 32'h80);
        chk("t6_addr_before_rst", 32'(o8Addr), 32'd1);
        iReset = 1'b1;
        #1;
        chk_all_zero("t6_async");
        exp_q.delete();
        active = 0;
        busy_chk_at = -1;
        err_chk_at = -1;
        n0 = wlog.size();
        repeat (3) @(negedge iClk);
        #1;
        iReset = 1'b0;
        repeat (5) @(negedge iClk);
        #1;
        chk("t6_no_writes_after_rst", 32'(wlog.size()), 32'(n0));
        cmdq.push_back(32'h80_00_00_02);
        wait_idle(200);
        chk_word("t6_new_hdr", n0, 16'hA507);
        chk_word("t6_new_s0", n0 + 1, 16'h0800);
        chk_word("t6_new_s1", n0 + 2, 16'h0801);

        // Random commands with random backpressure.
        clear_logs();
        total = 0;
        bp_rand = 1;
        for (int i = 0; i < 12; i++) begin
            rs   = $urandom_range(0, 70);
            rcnt = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
            rc[31:24] = 8'($urandom);
            rc[23:16] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            rc[15:8]  = 8'(rs);
            rc[7:0]   = 8'(rcnt);
            if (rc[31:24] != 0 && rc[23:16] == 0 && rs < DEPTH && rs + rcnt <= DEPTH)
                total += $countones(rc[31:24]) * (1 + ((rcnt == 0) ? DEPTH - rs : rcnt));
            cmdq.push_back(rc);
        end
        wait_idle(60000);
        bp_rand = 0;
        chk("rand_total_writes", 32'(wlog.size()), 32'(total));
        chk("rand_model_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
